// File: rtl/avg_operand_loader_pkg.sv
// Shared definitions for the 8-operand averaging datapath: operand count,
// slot index width, the operand-frame type and slot-mask helpers.
package avg_operand_loader_pkg;

    localparam int NUM_OPERANDS  = 8;
    localparam int IDX_W         = 3;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_SAWIDTH   = 8;

    typedef struct packed {
        logic [NUM_OPERANDS-1:0][DEF_DATAWIDTH-1:0] ops;
        logic [DEF_SAWIDTH-1:0]                     sa;
        logic                                       short_flag;
    } operand_frame_t;

    function automatic logic [NUM_OPERANDS-1:0] slot_onehot(input logic [IDX_W-1:0] idx);
        return NUM_OPERANDS'(1) << idx;
    endfunction

    // Slots strictly above idx: the ones an early-closed frame must zero-fill.
    function automatic logic [NUM_OPERANDS-1:0] pad_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_OPERANDS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            m[i] = (i > int'(idx));
        end
        return m;
    endfunction

endpackage

// File: rtl/avg_operand_loader_frame_bank.sv
// One operand-frame register: per-slot write enables, synchronous zero-pad
// mask (pad wins over write), and separately enabled sa / short fields.
module frame_bank
    import avg_operand_loader_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int SAWIDTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_OPERANDS-1:0]              slot_we,
    input  logic [NUM_OPERANDS-1:0]              pad,
    input  logic [NUM_OPERANDS-1:0][DATAWIDTH-1:0] d_ops,
    input  logic                                 sa_we,
    input  logic [SAWIDTH-1:0]                   d_sa,
    input  logic                                 short_we,
    input  logic                                 d_short,
    output logic [NUM_OPERANDS-1:0][DATAWIDTH-1:0] ops,
    output logic [SAWIDTH-1:0]                   sa,
    output logic                                 short_flag
);

    // NOTE: the operand storage is reset on purpose: an aborted frame must
    // leave no residue, and the held outputs are defined as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops        <= '0;
            sa         <= '0;
            short_flag <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (pad[i])
                    ops[i] <= '0;
                else if (slot_we[i])
                    ops[i] <= d_ops[i];
            end
            if (sa_we)
                sa <= d_sa;
            if (short_we)
                short_flag <= d_short;
        end
    end

endmodule

// File: rtl/avg_operand_loader.sv
// Serial-to-frame loader: collects words into a fill bank and presents
// closed frames from a hold bank, double-buffered for one word per cycle.
module avg_operand_loader
    import avg_operand_loader_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int SAWIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [SAWIDTH-1:0]   in_sa,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] e,
    output logic [DATAWIDTH-1:0] f,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic [SAWIDTH-1:0]   sa,
    output logic                 short_frame,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    logic [IDX_W-1:0] idx, idx_next;
    logic             fill_full, fill_full_next, out_valid_next;
    logic             accept, pop, close, hold_free, load_in, load_fill, hold_load;
    logic             is_short, fill_short;
    logic [NUM_OPERANDS-1:0]                 fill_we, fill_pad, cur_onehot, cur_pad;
    logic [NUM_OPERANDS-1:0][DATAWIDTH-1:0] fill_ops, hold_ops, closed_ops, hold_d_ops;
    logic [SAWIDTH-1:0]                      fill_sa, closed_sa, hold_d_sa;
    logic                                    hold_d_short;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        accept     = in_valid & in_ready;
        pop        = out_valid & out_ready;
        close      = accept & ((idx == LAST_IDX) | in_last);
        is_short   = in_last & (idx != LAST_IDX);
        hold_free  = !out_valid | out_ready;
        load_in    = close & hold_free;
        load_fill  = fill_full & pop;
        hold_load  = load_in | load_fill;
        cur_onehot = slot_onehot(idx);
        cur_pad    = pad_mask(idx);
        fill_we    = accept ? cur_onehot : '0;
        fill_pad   = close ? cur_pad : '0;

        // The frame as it stands after this cycle's accept, for direct transfer.
        closed_ops = fill_ops;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (cur_pad[i])
                closed_ops[i] = '0;
            else if (cur_onehot[i])
                closed_ops[i] = in_data;
        end
        closed_sa = (idx == '0) ? in_sa : fill_sa;

        hold_d_ops   = load_fill ? fill_ops   : closed_ops;
        hold_d_sa    = load_fill ? fill_sa    : closed_sa;
        hold_d_short = load_fill ? fill_short : is_short;

        idx_next = idx;
        if (close)
            idx_next = '0;
        else if (accept)
            idx_next = idx + 1'b1;

        fill_full_next = fill_full;
        if (load_fill)
            fill_full_next = 1'b0;
        else if (close && !hold_free)
            fill_full_next = 1'b1;

        out_valid_next = out_valid;
        if (hold_load)
            out_valid_next = 1'b1;
        else if (pop)
            out_valid_next = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            fill_full <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            idx       <= idx_next;
            fill_full <= fill_full_next;
            out_valid <= out_valid_next;
        end
    end

    // Purely registered, so out_ready never reaches in_ready combinationally.
    assign in_ready = !fill_full;

    frame_bank #(.DATAWIDTH(DATAWIDTH), .SAWIDTH(SAWIDTH)) u_fill (
        .clk        (clk),
        .rst        (rst),
        .slot_we    (fill_we),
        .pad        (fill_pad),
        .d_ops      ({NUM_OPERANDS{in_data}}),
        .sa_we      (accept && (idx == '0)),
        .d_sa       (in_sa),
        .short_we   (close),
        .d_short    (is_short),
        .ops        (fill_ops),
        .sa         (fill_sa),
        .short_flag (fill_short)
    );

    frame_bank #(.DATAWIDTH(DATAWIDTH), .SAWIDTH(SAWIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .slot_we    ({NUM_OPERANDS{hold_load}}),
        .pad        ('0),
        .d_ops      (hold_d_ops),
        .sa_we      (hold_load),
        .d_sa       (hold_d_sa),
        .short_we   (hold_load),
        .d_short    (hold_d_short),
        .ops        (hold_ops),
        .sa         (sa),
        .short_flag (short_frame)
    );

    assign a = hold_ops[0];
    assign b = hold_ops[1];
    assign c = hold_ops[2];
    assign d = hold_ops[3];
    assign e = hold_ops[4];
    assign f = hold_ops[5];
    assign g = hold_ops[6];
    assign h = hold_ops[7];

endmodule

// File: tb/tb_avg_operand_loader.sv
// Directed bench for avg_operand_loader: hand-computed frames checked with
// immediate assertions, one summary line at the end.
module tb_avg_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [7:0]  in_sa;
    logic        in_last, in_valid, in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  sa;
    logic        short_frame, out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avg_operand_loader #(.DATAWIDTH(16), .SAWIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sa       (in_sa),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .e           (e),
        .f           (f),
        .g           (g),
        .h           (h),
        .sa          (sa),
        .short_frame (short_frame),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First `count` operands base, base+step, ...; remaining operands zero. a is most significant.
    function automatic logic [127:0] seq(input logic [15:0] base, input logic [15:0] step, input int count);
        logic [7:0][15:0] r;
        r = '0;
        for (int i = 0; i < count; i++) r[7-i] = base + 16'(i) * step;
        return r;
    endfunction

    function automatic logic [127:0] ops_now();
        return {a, b, c, d, e, f, g, h};
    endfunction

    task automatic send(input logic [15:0] dv, input logic [7:0] sv, input logic lv);
        in_valid = 1'b1;
        in_data  = dv;
        in_sa    = sv;
        in_last  = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [127:0] ops, input logic [7:0] sv, input logic sh);
        check({tag, " valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, " ops"},   ops_now(), ops);
        check({tag, " sa"},    128'(sa), 128'(sv));
        check({tag, " short"}, 128'(short_frame), 128'(sh));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_sa = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("reset out_valid", 128'(out_valid), 128'(1'b0));
        check("reset in_ready",  128'(in_ready),  128'(1'b1));
        check("reset ops",       ops_now(),       '0);
        check("reset sa",        128'(sa),        '0);
        check("reset short",     128'(short_frame), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full frame 1..8, sa=3, consumer ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 8'd3, 1'b0);
            if (i < 8) check("t1 no early valid", 128'(out_valid), 128'(1'b0));
        end
        check_frame("t1 frame", seq(16'd1, 16'd1, 8), 8'd3, 1'b0);
        idle(1);
        check("t1 popped", 128'(out_valid), 128'(1'b0));

        // Early close after three words: d..h zero-padded.
        send(16'd10, 8'd5, 1'b0);
        send(16'd20, 8'd5, 1'b0);
        send(16'd30, 8'd5, 1'b1);
        check_frame("t2 short", seq(16'd10, 16'd10, 3), 8'd5, 1'b1);
        idle(1);

        // Two frames with consumer stalled: second parks in fill bank.
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check("t3 ready before word", 128'(in_ready), 128'(1'b1));
            send(16'(i), (i <= 8) ? 8'd1 : 8'd2, 1'b0);
        end
        check("t3 stall in_ready", 128'(in_ready), 128'(1'b0));
        check_frame("t3 frame1", seq(16'd1, 16'd1, 8), 8'd1, 1'b0);
        idle(1);
        check("t3 held stable a", 128'(a), 128'(16'd1));
        out_ready = 1'b1;
        idle(1);
        check_frame("t3 frame2", seq(16'd9, 16'd1, 8), 8'd2, 1'b0);
        check("t3 in_ready back", 128'(in_ready), 128'(1'b1));
        idle(1);
        check("t3 drained", 128'(out_valid), 128'(1'b0));

        // 24-word continuous stream, no bubbles.
        for (int i = 0; i < 24; i++) begin
            check("t4 in_ready high", 128'(in_ready), 128'(1'b1));
            send(16'(200 + i), 8'(i / 8), 1'b0);
            check("t4 out_valid timing", 128'(out_valid), 128'((i % 8) == 7));
            if ((i % 8) == 7)
                check_frame("t4 frame", seq(16'(193 + i), 16'd1, 8), 8'(i / 8), 1'b0);
        end
        idle(1);

        // Async reset mid-frame with a frame held.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(16'(i), 8'd4, 1'b0);
        for (int i = 0; i < 5; i++) send(16'(50 + i), 8'd6, 1'b0);
        in_valid = 1'b0;
        check("t5 held before rst", 128'(out_valid), 128'(1'b1));
        #3 rst = 1'b1;
        #1;
        check("t5 rst out_valid", 128'(out_valid), 128'(1'b0));
        check("t5 rst ops",       ops_now(),       '0);
        check("t5 rst in_ready",  128'(in_ready),  128'(1'b1));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(100 + i), 8'd9, 1'b0);
        check_frame("t5 fresh", seq(16'd100, 16'd1, 8), 8'd9, 1'b0);
        idle(1);

        // sa changes mid-frame, gaps in in_valid, in_last on the 8th word.
        send(16'h1111, 8'd3, 1'b0);
        idle(2);
        check("t6 gap no valid", 128'(out_valid), 128'(1'b0));
        send(16'h2222, 8'd7, 1'b0);
        send(16'h3333, 8'd7, 1'b0);
        idle(1);
        for (int i = 4; i <= 7; i++) send(16'(16'h1111 * i), 8'd7, 1'b0);
        idle(3);
        send(16'h8888, 8'd7, 1'b1);
        check_frame("t6 gapped", seq(16'h1111, 16'h1111, 8), 8'd3, 1'b0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_operand_loader.md
Name: avg_operand_loader

Overview:
- Producer-side front end for the 8-operand averaging datapath.
- Accepts a serial stream of DATAWIDTH-bit samples using a valid/ready handshake and assembles them into frames of 8 operands, a..h.
- Each frame is presented as a held parallel bundle, with the frame's shift amount, under a valid/ready handshake.
- Double-buffered: a fill bank collects words while a hold bank presents the previous frame, so sustained throughput is one word per cycle.

Parameters:
- DATAWIDTH, 16, width of each sample and each operand output
- SAWIDTH, 8, width of the shift-amount field captured per frame

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATAWIDTH  sample word
- in_sa  input  SAWIDTH  shift amount, sampled with the first word of a frame
- in_last  input  1  marks the final word of a frame; may close a frame early
- in_valid  input  1  word offered
- in_ready  output  1  loader can accept a word this cycle
- a, b, c, d, e, f, g, h  output  DATAWIDTH each  operands 0..7 of the held frame
- sa  output  SAWIDTH  shift amount of the held frame
- short_frame  output  1  held frame closed early by in_last and was zero-padded
- out_valid  output  1  held frame is valid
- out_ready  input  1  consumer accepts the held frame

Behaviour:
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output pop = out_valid & out_ready.
  - While out_valid=1, all outputs stay stable until pop.
- Reset (async, immediate):
  - out_valid=0, short_frame=0, a..h=0, sa=0, in_ready=1.
  - Fill index=0, fill_full=0, fill bank cleared.
  - A frame in progress is discarded; no partial frame survives reset.
- Fill bank:
  - An index 0..7 selects the slot; slot i maps to operand a+i (a=slot 0, h=slot 7).
  - On accept at index 0, in_sa is captured.
  - Each accept writes in_data to the slot and increments the index.
- Frame close happens on an accept where index==7, or where in_last=1 at any index.
  - On early close, slots index+1..7 are zero-filled and the frame's short_frame=1.
  - in_last on the 8th word is a normal close, with short_frame=0.
  - The index returns to 0 on close.
- Transfer on close:
  - If the hold bank is empty, or a pop occurs in the same cycle, the closed frame (including the word accepted this cycle) loads into the hold bank at that edge and out_valid=1 next cycle.
  - Otherwise the frame is kept in the fill bank and fill_full=1.
- Stall and drain:
  - in_ready = !fill_full, driven from a register with no combinational path from out_ready.
  - While fill_full=1, a pop loads the fill bank into hold at that edge, and fill_full=0 from the next cycle.
- Latency: a closing accept at edge N with the hold bank free gives out_valid=1 in cycle N+1.
- Throughput: back-to-back frames with out_ready=1 give no bubbles on in_ready.
- Pop with no new frame ready: out_valid=0 next cycle; a..h keep their stale values (don't-care).
- Width rules: no arithmetic; data is passed bit-exact; padding is all-zero DATAWIDTH words.
- in_sa is ignored on non-first words; a change mid-frame has no effect.
- in_valid=0 leaves all fill state unchanged, including mid-frame.

Decomposition:
- Shared package (also used by the averaging datapath):
  - NUM_OPERANDS=8 and index width 3.
  - An operand-frame typedef: 8×DATAWIDTH operands, SAWIDTH sa, 1-bit short flag.
- One natural sub-module, frame_bank: a frame register with load enable and synchronous zero-pad mask, instantiated twice (fill, hold).
- Control (index counter, fill_full, out_valid) stays in the top.

Test Plan:
- Reset, then words 1..8 with in_sa=3 and out_ready=1:
  - out_valid=1 one cycle after the 8th accept.
  - a..h=1..8, sa=3, short_frame=0.
- Words 10,20,30 with in_last on 30:
  - a=10, b=20, c=30, d..h=0, short_frame=1.
- Two frames back-to-back (1..8, then 9..16) with out_ready=0:
  - in_ready falls after word 16.
  - Raising out_ready pops frame 1 (a=1), then frame 2 (a=9).
  - in_ready=1 the cycle after the second-frame transfer.
- Continuous stream of 24 words with out_ready=1:
  - in_ready never drops.
  - Three frames emitted, each out_valid one cycle after its closing accept.
- rst asserted asynchronously after 5 words of a frame, then 8 fresh words 100..107:
  - out_valid drops immediately on rst.
  - Next frame has a=100..h=107 with no residue from the aborted frame.
- in_sa changed 3→7 mid-frame and in_valid gapped between words:
  - sa=3 on output; operands are correct and in order despite the gaps.
